// File: rtl/sum_accum.sv
// Block accumulator behind the 4+4 adder: sums COUNT samples, tracks max/overflow.
// Define SUM_ACCUM_SAT_EN to saturate the accumulator instead of wrapping.
module sum_accum #(
  parameter int SUM_W = 5,
  parameter int COUNT = 4,
  parameter int ACC_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [SUM_W-1:0] out_max,
  output logic             out_ovf
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc;
  logic [SUM_W-1:0] r_max;
  logic [SUM_W-1:0] w_max;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_ovf;
  logic [ACC_W:0]   w_sum;
  logic             w_accept;
  logic             w_xfer;
  logic             w_last;
  logic             r_valid;
  logic [ACC_W-1:0] r_total;
  logic [SUM_W-1:0] r_omax;
  logic             r_oovf;

  assign in_ready  = ~rst & (r_state != HOLD);
  assign w_accept  = in_valid & in_ready;
  assign w_xfer    = r_valid & out_ready;
  assign w_last    = (r_cnt == LAST);
  assign out_valid = r_valid;
  assign out_total = r_total;
  assign out_max   = r_omax;
  assign out_ovf   = r_oovf;

  always_comb begin
    w_sum = {1'b0, r_acc} + (ACC_W + 1)'(in_sum);
    w_ovf = r_ovf | w_sum[ACC_W];
    w_max = (in_sum > r_max) ? in_sum : r_max;
`ifdef SUM_ACCUM_SAT_EN
    w_acc = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
`else
    w_acc = w_sum[ACC_W-1:0];
`endif
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, ACCUM: begin
        if (w_accept) w_next = w_last ? HOLD : ACCUM;
      end
      HOLD: begin
        if (w_xfer) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_max   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_total <= '0;
      r_omax  <= '0;
      r_oovf  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_acc <= w_acc;
        r_max <= w_max;
        r_cnt <= r_cnt + 1'b1;
        r_ovf <= w_ovf;
        if (w_last) begin
          r_total <= w_acc;
          r_omax  <= w_max;
          r_oovf  <= w_ovf;
          r_valid <= 1'b1;
        end
      end
      // Totals stay visible after transfer; only the block state restarts.
      if (w_xfer) begin
        r_valid <= 1'b0;
        r_acc   <= '0;
        r_max   <= '0;
        r_cnt   <= '0;
        r_ovf   <= 1'b0;
      end
    end
  end

endmodule
